wb_master_arbiter: RTL

WB_MASTER_ARBITER -- requirements
Module: wb_master_arbiter

---
 rtl/wb_master_arbiter.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/wb_master_arbiter.sv
// ---------------------------------------------------------------------------
// wb_master_arbiter
//
// Two-requester Wishbone arbiter. A fetch requester (f) and a data requester
// (d) share one Wishbone master port. Grants are taken from IDLE only. When
// both requesters ask in the same cycle, the one not granted last wins.
// A granted requester keeps the bus for as long as it holds its cyc high.
// Every grant is followed by at least one bus-idle cycle.
// A watchdog counts stalled cycles. When the count reaches TIMEOUT it raises
// a forced error to the granted requester.
//
// Handshake: a requester asserts cyc (with stb/we/addr/dat) and holds it. The
// bus request is presented combinationally while the requester is granted.
// An ack or err from the slave completes a beat. The response is routed
// only to the granted requester, and only while that requester's cyc is
// high. A response that arrives in IDLE is discarded.
//
// Parameters:
//   TIMEOUT  stall cycles before a forced error; 0 disables the watchdog.
//            The value must fit in TW bits.
//   TW       watchdog counter width.
//
// Ports:
//   i_clk, i_reset            clock and synchronous active-high reset
//   i_f_* / o_f_*             fetch requester request and response
//   i_d_* / o_d_*             data requester request and response
//   o_wb_* / i_wb_*           shared Wishbone master port
//   o_grant                   registered one-hot grant (bit0 = fetch,
//                             bit1 = data); also exposes the FSM state
//   o_timeout                 one-cycle pulse on watchdog expiry
// ---------------------------------------------------------------------------
module wb_master_arbiter #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TW      = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,

    input  logic        i_f_cyc,
    input  logic        i_f_we,
    input  logic [3:0]  i_f_stb,
    input  logic [31:0] i_f_addr,
    input  logic [31:0] i_f_dat,
    output logic [31:0] o_f_dat,
    output logic        o_f_ack,
    output logic        o_f_err,

    input  logic        i_d_cyc,
    input  logic        i_d_we,
    input  logic [3:0]  i_d_stb,
    input  logic [31:0] i_d_addr,
    input  logic [31:0] i_d_dat,
    output logic [31:0] o_d_dat,
    output logic        o_d_ack,
    output logic        o_d_err,

    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_stb,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,

    output logic [1:0]  o_grant,
    output logic        o_timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_F = 2'd1,
        GNT_D = 2'd2
    } state_t;

    localparam logic [TW-1:0] TO_VAL = TW'(TIMEOUT);
    localparam bit            WD_ON  = (TIMEOUT != 0);

    state_t        state;
    logic          last_d;      // 1 when the data requester was granted last
    logic [TW-1:0] wd_cnt;

    // Request of whichever requester currently owns the bus.
    logic        g_cyc;
    logic        g_we;
    logic [3:0]  g_stb;
    logic [31:0] g_addr;
    logic [31:0] g_dat;

    logic wb_resp;   // slave responses may be forwarded this cycle
    logic ack_fwd;
    logic err_fwd;
    logic expire;

    always_comb begin
        g_cyc  = 1'b0;
        g_we   = 1'b0;
        g_stb  = 4'd0;
        g_addr = 32'd0;
        g_dat  = 32'd0;
        case (state)
            GNT_F: begin
                g_cyc  = i_f_cyc;
                g_we   = i_f_we;
                g_stb  = i_f_stb;
                g_addr = i_f_addr;
                g_dat  = i_f_dat;
            end
            GNT_D: begin
                g_cyc  = i_d_cyc;
                g_we   = i_d_we;
                g_stb  = i_d_stb;
                g_addr = i_d_addr;
                g_dat  = i_d_dat;
            end
            default: begin
            end
        endcase
    end

    // A response during the reset cycle is dropped as well. The bus is
    // being torn down, so the requester must not see a completion.
    assign wb_resp = !i_reset && (state != IDLE) && g_cyc;
    assign err_fwd = wb_resp && i_wb_err;
    assign ack_fwd = wb_resp && i_wb_ack && !i_wb_err;

    // A real ack/err in the expiry cycle wins over the forced timeout.
    assign expire = WD_ON && wb_resp && (g_stb != 4'd0) && (wd_cnt == TO_VAL)
                    && !i_wb_ack && !i_wb_err;

    assign o_wb_cyc  = g_cyc && !expire;
    assign o_wb_stb  = g_stb;
    assign o_wb_we   = g_we;
    assign o_wb_addr = g_addr;
    assign o_wb_dat  = g_dat;

    assign o_f_dat = i_wb_dat;
    assign o_d_dat = i_wb_dat;

    assign o_f_ack = ack_fwd && (state == GNT_F);
    assign o_f_err = (err_fwd || expire) && (state == GNT_F);
    assign o_d_ack = ack_fwd && (state == GNT_D);
    assign o_d_err = (err_fwd || expire) && (state == GNT_D);

    assign o_timeout = expire;

    // Grant FSM. o_grant is registered next to the state, so it always
    // matches the state one-hot.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= IDLE;
            last_d  <= 1'b0;
            o_grant <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (i_f_cyc && i_d_cyc) begin
                        if (last_d) begin
                            state   <= GNT_F;
                            last_d  <= 1'b0;
                            o_grant <= 2'b01;
                        end else begin
                            state   <= GNT_D;
                            last_d  <= 1'b1;
                            o_grant <= 2'b10;
                        end
                    end else if (i_f_cyc) begin
                        state   <= GNT_F;
                        last_d  <= 1'b0;
                        o_grant <= 2'b01;
                    end else if (i_d_cyc) begin
                        state   <= GNT_D;
                        last_d  <= 1'b1;
                        o_grant <= 2'b10;
                    end
                end
                GNT_F: begin
                    if (!i_f_cyc) begin
                        state   <= IDLE;
                        o_grant <= 2'b00;
                    end
                end
                GNT_D: begin
                    if (!i_d_cyc) begin
                        state   <= IDLE;
                        o_grant <= 2'b00;
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_grant <= 2'b00;
                end
            endcase
        end
    end

    // Watchdog. It counts only genuinely stalled beats. The count saturates
    // at TIMEOUT, so with TIMEOUT = 0 it never leaves zero.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wd_cnt <= '0;
        end else if ((state == IDLE) || !g_cyc || (g_stb == 4'd0) ||
                     i_wb_ack || i_wb_err || expire) begin
            wd_cnt <= '0;
        end else if (wd_cnt != TO_VAL) begin
            wd_cnt <= wd_cnt + TW'(1);
        end
    end

endmodule
